mem_access_unit: RTL and testbench

- Memory-stage access sequencer between the EX/MEM pipeline register and the word-addressed data memory.
- Turns byte/halfword/word loads and stores (lb, lbu, lh, lhu, lw, sb, sh, sw) into single-cycle read/write strobe pulses on the word memory.
- Sub-word stores use read-modify-write. Sub-word loads are sign- or zero-extended.
- Stalls the pipeline with busy until the access completes.

---
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: pipeline request/response side plus the
// word-memory strobe side. The unit itself uses the slave modport.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata, mem_rdata,
        output busy, done, err, rdata, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req, we, size, unsigned_ld, addr, wdata, mem_rdata,
        input  busy, done, err, rdata, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access sequencer: byte/half/word loads and stores on a word memory,
// sub-word stores by read-modify-write. Define MEM_ACCESS_ALIGN_CHECK_EN to flag misalignment.
module mem_access_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [1:0]  lane_reg;
    logic [15:0] wdata_reg;

    logic        busy_reg, done_reg, err_reg, mem_read_reg, mem_write_reg;
    logic [31:0] rdata_reg, mem_addr_reg, mem_wdata_reg;

    logic        acc_err;
    logic [1:0]  lane_next;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [31:0] merged;

    // Request decode: error detection and the effective byte lane.
    always_comb begin
        lane_next = bus.addr[1:0];
        acc_err   = (bus.size == 2'b11) || ((bus.addr >> 2) >= 32'(MEM_WORDS));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if (bus.size == 2'b01 && bus.addr[0])
            acc_err = 1'b1;
        if (bus.size == 2'b10 && bus.addr[1:0] != 2'b00)
            acc_err = 1'b1;
`else
        if (bus.size == 2'b01)
            lane_next[0] = 1'b0;
        else if (bus.size == 2'b10)
            lane_next = 2'b00;
`endif
    end

    // Load lane extraction and extension.
    always_comb begin
        sel_byte = bus.mem_rdata[{lane_reg, 3'b000} +: 8];
        sel_half = bus.mem_rdata[{lane_reg[1], 4'b0000} +: 16];
        case (size_reg)
            2'b00:   load_val = {{24{~uns_reg & sel_byte[7]}}, sel_byte};
            2'b01:   load_val = {{16{~uns_reg & sel_half[15]}}, sel_half};
            default: load_val = bus.mem_rdata;
        endcase
    end

    // Byte enables and replicated store data for the read-modify-write merge.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = {2{wdata_reg}};
        if (size_reg == 2'b00) begin
            byte_en   = 4'b0001 << lane_reg;
            wdata_rep = {4{wdata_reg[7:0]}};
        end else if (size_reg == 2'b01) begin
            byte_en   = lane_reg[1] ? 4'b1100 : 4'b0011;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8]
                                                   : bus.mem_rdata[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.req) begin
                if (acc_err)
                    state_next = DONE;
                else if (bus.we && bus.size == 2'b10)
                    state_next = WR;
                else
                    state_next = RD;
            end
            RD:      state_next = we_reg ? WR : DONE;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status and strobes are registered from the next state so each strobe
    // is exactly one cycle wide and drops at once under reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            size_reg      <= 2'b00;
            uns_reg       <= 1'b0;
            lane_reg      <= 2'b00;
            wdata_reg     <= 16'h0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            rdata_reg     <= 32'h0;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
        end else begin
            state_reg     <= state_next;
            busy_reg      <= (state_next != IDLE);
            done_reg      <= (state_next == DONE);
            mem_read_reg  <= (state_next == RD);
            mem_write_reg <= (state_next == WR);
            err_reg       <= 1'b0;
            case (state_reg)
                IDLE: if (bus.req) begin
                    we_reg       <= bus.we;
                    size_reg     <= bus.size;
                    uns_reg      <= bus.unsigned_ld;
                    lane_reg     <= lane_next;
                    wdata_reg    <= bus.wdata[15:0];
                    mem_addr_reg <= bus.addr >> 2;
                    if (acc_err) begin
                        err_reg   <= 1'b1;
                        rdata_reg <= 32'h0;
                    end else if (bus.we && bus.size == 2'b10) begin
                        mem_wdata_reg <= bus.wdata;
                    end
                end
                RD: begin
                    if (we_reg)
                        mem_wdata_reg <= merged;
                    else
                        rdata_reg <= load_val;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.rdata     = rdata_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_read  = mem_read_reg;
    assign bus.mem_write = mem_write_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-arithmetic
// reference model and a strobe-driven word memory.
module tb_mem_access_unit;

    localparam int MEM_WORDS = 1024;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    logic clk;
    logic rst_n;
    mem_access_unit_if bus();

    mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic [31:0] exp_rdata;
    int n_tests, n_fail;
    int rd_cnt, wr_cnt, both_hi;

    always @(posedge bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    always @(posedge bus.mem_write) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

    always @(posedge clk) begin
        if (bus.mem_read)  rd_cnt++;
        if (bus.mem_write) wr_cnt++;
        if (bus.mem_read && bus.mem_write) both_hi++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: byte-level effect of one access on memory, rdata and timing.
    task automatic model(input bit w, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output bit e, output int lat, output int nrd, output int nwr);
        int nbytes, off, idx;
        logic [31:0] mask, val;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = (sz == 2'd3) || (a >= ADDR_LIMIT);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if (sz != 2'd3 && (a % nbytes) != 0) e = 1'b1;
`endif
        if (e) begin
            exp_rdata = 32'h0;
            lat = 1; nrd = 0; nwr = 0;
            return;
        end
        off = int'(a % 4);
        off = off - (off % nbytes);
        idx = int'(a / 4);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        if (!w) begin
            val = (ref_mem[idx] >> (8 * off)) & mask;
            if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
            exp_rdata = val;
            lat = 2; nrd = 1; nwr = 0;
        end else begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            lat = (nbytes == 4) ? 2 : 3;
            nrd = (nbytes == 4) ? 0 : 1;
            nwr = 1;
        end
    endtask

    task automatic access(input bit w, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd);
        bit e, seen;
        int lat, nrd, nwr, got_lat;
        model(w, sz, uns, a, wd, e, lat, nrd, nwr);
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.unsigned_ld = uns;
        bus.addr = a; bus.wdata = wd;
        rd_cnt = 0; wr_cnt = 0;
        seen = 1'b0; got_lat = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                got_lat = c;
            end
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(got_lat), 32'(lat));
        check_eq("err", 32'(bus.err), 32'(e));
        check_eq("busy_at_done", 32'(bus.busy), 32'd1);
        check_eq("rdata", bus.rdata, exp_rdata);
        bus.req = 1'b0;
        @(negedge clk);
        check_eq("busy_idle", 32'(bus.busy), 32'd0);
        check_eq("done_pulse", 32'(bus.done), 32'd0);
        check_eq("err_clear", 32'(bus.err), 32'd0);
        check_eq("rd_pulses", 32'(rd_cnt), 32'(nrd));
        check_eq("wr_pulses", 32'(wr_cnt), 32'(nwr));
        if (!e) check_eq("mem_word", mem[a[11:2]], ref_mem[a[11:2]]);
        $display("[TB] %s sz=%0d uns=%0d addr=0x%08h wdata=0x%08h -> err=%0d rdata=0x%08h lat=%0d",
                 w ? "ST" : "LD", sz, uns, a, wd, bus.err, bus.rdata, got_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rw, ru;
        logic [1:0] rs;
        logic [31:0] ra;
        n_tests = 0; n_fail = 0; rd_cnt = 0; wr_cnt = 0; both_hi = 0;
        exp_rdata = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.unsigned_ld = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0; bus.mem_rdata = 32'h0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access(1'b1, 2'b10, 1'b0, 32'h14, 32'h1122_3344);
        check_eq("plan1_mem", mem[5], 32'h1122_3344);
        access(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_00AB);
        check_eq("plan2_mem", mem[5], 32'h1122_AB44);
        access(1'b0, 2'b01, 1'b0, 32'h14, 32'h0);
        check_eq("plan3_lh", bus.rdata, 32'hFFFF_AB44);
        access(1'b0, 2'b01, 1'b1, 32'h14, 32'h0);
        check_eq("plan3_lhu", bus.rdata, 32'h0000_AB44);
        access(1'b0, 2'b00, 1'b0, 32'h17, 32'h0);
        check_eq("plan3_lb", bus.rdata, 32'h0000_0011);
        access(1'b0, 2'b10, 1'b0, 32'h16, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        access(1'b1, 2'b11, 1'b0, 32'h20, 32'hDEAD_BEEF);

        // Reset while the RMW of a halfword store is in its read cycle.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b01; bus.unsigned_ld = 1'b0;
        bus.addr = 32'h14; bus.wdata = 32'h0000_BEEF;
        rd_cnt = 0; wr_cnt = 0;
        @(negedge clk);
        check_eq("rst6_in_rd", 32'(bus.mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst6_busy", 32'(bus.busy), 32'd0);
        check_eq("rst6_done_err", {30'd0, bus.done, bus.err}, 32'd0);
        check_eq("rst6_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check_eq("rst6_rdata", bus.rdata, 32'h0);
        check_eq("rst6_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst6_mem_wdata", bus.mem_wdata, 32'h0);
        bus.req = 1'b0;
        exp_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst6_no_write", 32'(wr_cnt), 32'd0);
        check_eq("rst6_mem", mem[5], 32'h1122_AB44);
        access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        check_eq("plan6_lw", bus.rdata, 32'h1122_AB44);

        for (int n = 0; n < 150; n++) begin
            rw = 1'($urandom_range(0, 1));
            ru = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
            ra = ($urandom_range(0, 9) == 0) ? ADDR_LIMIT + 32'($urandom_range(0, 63))
                                             : 32'($urandom_range(0, 63));
            access(rw, rs, ru, ra, $urandom);
        end

        check_eq("no_dual_strobe", 32'(both_hi), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
